// File: rtl/dac_pkg.sv
// Shared types and defaults for the 1-bit DAC output stage.
package dac_pkg;

   typedef enum logic {
      MODE_PWM = 1'b0,
      MODE_DSM = 1'b1
   } dac_mode_t;

   localparam int unsigned DAC_WIDTH = 10;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; pointers carry an extra wrap bit to tell full from empty.
module sample_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dac_modulator.sv
// Single-pin DAC stage: buffers upstream samples and renders the active one as
// PWM or first-order delta-sigma, popping one sample per 2^WIDTH cycles.
module dac_modulator
   import dac_pkg::*;
#(
   parameter int unsigned WIDTH      = DAC_WIDTH,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             enable,
   input  logic             mode,
   input  logic             clear_underrun,
   output logic             dac_out,
   output logic             period_start,
   output logic             underrun
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   dac_mode_t        mode_q, mode_d;
   logic             dac_d;
   logic             underrun_d;
   logic             boundary_c;
   logic             pop_c;
   logic             push_c;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH-1:0] head_c;
   logic             full_c;
   logic             empty_c;

   assign push_c  = s_valid && !full_c;
   assign s_ready = !full_c;

   sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (s_data),
      .pop       (pop_c),
      .head      (head_c),
      .full      (full_c),
      .empty     (empty_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state plus the values the output flop must show in the coming cycle.
   always_comb begin
      state_d    = enable ? ST_RUN : ST_IDLE;
      boundary_c = 1'b0;
      cnt_d      = '0;
      active_d   = active_q;
      acc_d      = acc_q;
      mode_d     = mode_q;
      dac_d      = 1'b0;
      sum_c      = '0;
      underrun_d = underrun_q_hold();

      if (enable) begin
         boundary_c = (state_q == ST_IDLE) || (cnt_q == '1);
      end
      pop_c = boundary_c && !empty_c;

      if (clear_underrun)         underrun_d = 1'b0;
      if (boundary_c && empty_c)  underrun_d = 1'b1;

      if (state_d == ST_RUN) begin
         if (boundary_c) begin
            cnt_d  = '0;
            mode_d = dac_mode_t'(mode);
            if (!empty_c) active_d = head_c;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
         // The accumulator advances on the edge into each run cycle so the carry is flop-ready.
         sum_c = {1'b0, acc_q} + {1'b0, active_d};
         if (mode_d == MODE_DSM) begin
            acc_d = sum_c[WIDTH-1:0];
            dac_d = sum_c[WIDTH];
         end else begin
            dac_d = (cnt_d < active_d);
         end
      end
   end

   function automatic logic underrun_q_hold();
      return underrun;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         active_q     <= '0;
         acc_q        <= '0;
         mode_q       <= MODE_PWM;
         dac_out      <= 1'b0;
         period_start <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         acc_q        <= acc_d;
         mode_q       <= mode_d;
         dac_out      <= dac_d;
         period_start <= boundary_c;
         underrun     <= underrun_d;
      end
   end

endmodule
